// File: rtl/oled_pkg.sv
// Shared SSD1331 opcodes, screen geometry and controller state encoding
// for the multi-bar OLED drawer.
package oled_pkg;

  localparam logic [7:0] OP_DRAW_RECT = 8'h22;
  localparam logic [7:0] OP_CLR_WIN   = 8'h25;
  localparam logic [7:0] OP_FILL      = 8'h26;

  localparam int SCR_W = 96;
  localparam int SCR_H = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SCAN,
    ST_CLR,
    ST_CWAIT,
    ST_RECT,
    ST_UPD,
    ST_DONE
  } state_t;

  // Heights above the panel are drawn as a full-height bar.
  function automatic logic [7:0] clamp_h(input logic [7:0] y);
    return (y > 8'(SCR_H)) ? 8'(SCR_H) : y;
  endfunction

endpackage

// File: rtl/oled_cmd_tx.sv
// Byte launcher: walks a multi-byte command one byte at a time through
// the spi_master handshake and flags the completion of the final byte.
module oled_cmd_tx (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       active_i,
  input  logic [3:0] n_bytes_i,
  input  logic [7:0] byte_i,
  input  logic       spi_done_i,
  output logic [3:0] byte_idx_o,
  output logic       spi_en_o,
  output logic [7:0] data_o,
  output logic       last_o
);

  // Handshake: spi_en_o pulses for one cycle with data_o valid; data_o stays
  // put until spi_done_i; the next launch comes the cycle after spi_done_i;
  // spi_done_i with nothing outstanding is ignored.
  logic outstanding;

  assign spi_en_o = active_i & ~outstanding;
  assign data_o   = active_i ? byte_i : 8'h00;
  assign last_o   = outstanding & spi_done_i & (byte_idx_o == n_bytes_i - 4'd1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      outstanding <= 1'b0;
      byte_idx_o  <= 4'd0;
    end else if (!active_i) begin
      outstanding <= 1'b0;
      byte_idx_o  <= 4'd0;
    end else if (spi_en_o) begin
      outstanding <= 1'b1;
    end else if (outstanding && spi_done_i) begin
      outstanding <= 1'b0;
      byte_idx_o  <= last_o ? 4'd0 : byte_idx_o + 4'd1;
    end
  end

endmodule

// File: rtl/oled_multibar_ctrl.sv
// N-channel bar-graph drawer for the SSD1331: redraws only bars whose
// height changed since they were last drawn, or every bar when forced.
module oled_multibar_ctrl
  import oled_pkg::*;
#(
  parameter int          N_BARS   = 4,
  parameter int          BAR_W    = 20,
  parameter int          BAR_GAP  = 4,
  parameter logic [23:0] BAR_RGB  = 24'h3F_00_20,
  parameter int          CLR_WAIT = 400
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  force_i,
  input  logic [8*N_BARS-1:0]   y_i,
  input  logic                  spi_done_i,
  output logic                  spi_en_o,
  output logic [7:0]            data_o,
  output logic                  dc_o,
  output logic                  busy_o,
  output logic                  done_o,
  output state_t                state_o
);

  localparam int PITCH = BAR_W + BAR_GAP;
  localparam logic [15:0] WAIT_END = 16'(CLR_WAIT - 1);

  if (N_BARS < 1 || N_BARS > 8) begin : g_bad_nbars
    $error("oled_multibar_ctrl: N_BARS must be 1..8");
  end
  if (N_BARS * PITCH - BAR_GAP > SCR_W) begin : g_bad_width
    $error("oled_multibar_ctrl: bars do not fit in the panel width");
  end
  if (CLR_WAIT < 1) begin : g_bad_wait
    $error("oled_multibar_ctrl: CLR_WAIT must be at least 1");
  end

  state_t              state, state_n;
  logic [3:0]          idx;
  logic [7:0]          snap   [N_BARS];
  logic [7:0]          shadow [N_BARS];
  logic [N_BARS-1:0]   drawn_valid;
  logic                force_q, fill_on;
  logic [15:0]         wait_cnt;

  logic [7:0] cur_snap, cur_shadow, x0, x1, cur_byte;
  logic       cur_valid, need_draw, tx_active, tx_last;
  logic [3:0] n_bytes, byte_idx;

  always_comb begin
    cur_snap   = 8'h00;
    cur_shadow = 8'h00;
    cur_valid  = 1'b0;
    for (int i = 0; i < N_BARS; i++) begin
      if (idx == 4'(i)) begin
        cur_snap   = snap[i];
        cur_shadow = shadow[i];
        cur_valid  = drawn_valid[i];
      end
    end
  end

  assign x0        = 8'(idx * PITCH);
  assign x1        = x0 + 8'(BAR_W - 1);
  assign need_draw = force_q | ~cur_valid | (cur_snap != cur_shadow);
  assign tx_active = (state == ST_FILL) || (state == ST_CLR) || (state == ST_RECT);

  // Byte selection for the command currently being sent.
  always_comb begin
    n_bytes  = 4'd2;
    cur_byte = 8'h00;
    case (state)
      ST_FILL: begin
        n_bytes  = 4'd2;
        cur_byte = (byte_idx == 4'd0) ? OP_FILL : 8'h01;
      end
      ST_CLR: begin
        n_bytes = 4'd5;
        case (byte_idx)
          4'd0:    cur_byte = OP_CLR_WIN;
          4'd1:    cur_byte = x0;
          4'd2:    cur_byte = 8'h00;
          4'd3:    cur_byte = x1;
          default: cur_byte = 8'(SCR_H - 1);
        endcase
      end
      ST_RECT: begin
        n_bytes = 4'd11;
        case (byte_idx)
          4'd0:       cur_byte = OP_DRAW_RECT;
          4'd1:       cur_byte = x0;
          4'd2:       cur_byte = 8'(SCR_H) - cur_snap;
          4'd3:       cur_byte = x1;
          4'd4:       cur_byte = 8'(SCR_H - 1);
          4'd5, 4'd8: cur_byte = BAR_RGB[23:16];
          4'd6, 4'd9: cur_byte = BAR_RGB[15:8];
          default:    cur_byte = BAR_RGB[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start_i) state_n = fill_on ? ST_SCAN : ST_FILL;
      ST_FILL:  if (tx_last) state_n = ST_SCAN;
      ST_SCAN: begin
        if (idx == 4'(N_BARS)) state_n = ST_DONE;
        else if (need_draw)    state_n = ST_CLR;
      end
      ST_CLR:   if (tx_last) state_n = ST_CWAIT;
      ST_CWAIT: if (wait_cnt == WAIT_END) state_n = (cur_snap != 8'h00) ? ST_RECT : ST_UPD;
      ST_RECT:  if (tx_last) state_n = ST_UPD;
      ST_UPD:   state_n = ST_SCAN;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      idx         <= 4'd0;
      force_q     <= 1'b0;
      fill_on     <= 1'b0;
      wait_cnt    <= 16'd0;
      drawn_valid <= '0;
      for (int i = 0; i < N_BARS; i++) begin
        snap[i]   <= 8'h00;
        shadow[i] <= 8'h00;
      end
    end else begin
      state    <= state_n;
      wait_cnt <= (state == ST_CWAIT) ? wait_cnt + 16'd1 : 16'd0;
      if (state == ST_IDLE && start_i) begin
        idx     <= 4'd0;
        force_q <= force_i;
        for (int i = 0; i < N_BARS; i++) snap[i] <= clamp_h(y_i[8*i +: 8]);
      end
      if (state == ST_FILL && tx_last) fill_on <= 1'b1;
      if (state == ST_SCAN && idx != 4'(N_BARS) && !need_draw) idx <= idx + 4'd1;
      if (state == ST_UPD) begin
        for (int i = 0; i < N_BARS; i++) begin
          if (idx == 4'(i)) begin
            shadow[i]      <= snap[i];
            drawn_valid[i] <= 1'b1;
          end
        end
        idx <= idx + 4'd1;
      end
    end
  end

  oled_cmd_tx u_tx (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .active_i   (tx_active),
    .n_bytes_i  (n_bytes),
    .byte_i     (cur_byte),
    .spi_done_i (spi_done_i),
    .byte_idx_o (byte_idx),
    .spi_en_o   (spi_en_o),
    .data_o     (data_o),
    .last_o     (tx_last)
  );

  assign dc_o    = 1'b0;
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign state_o = state;

endmodule

// File: tb/tb_oled_multibar_ctrl.sv
// Self-checking bench for oled_multibar_ctrl: spi_master model, byte
// scoreboard driven by a reference model of which bars must be redrawn.
module tb_oled_multibar_ctrl;
  import oled_pkg::*;

  logic        clk_i, rstn_i, start_i, force_i, spi_done_i;
  logic [31:0] y_i;
  logic        spi_en_o, dc_o, busy_o, done_o;
  logic [7:0]  data_o;
  state_t      state_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_shadow [4];
  bit         m_valid  [4];
  bit         m_fill;
  int         bytes_sent;
  bit         inject;

  localparam logic [7:0] FRAME1 [55] = '{
    8'h26, 8'h01,
    8'h25, 8'h00, 8'h00, 8'h13, 8'h3F, 8'h22, 8'h00, 8'h36, 8'h13, 8'h3F, 8'h3F, 8'h00, 8'h20, 8'h3F, 8'h00, 8'h20,
    8'h25, 8'h18, 8'h00, 8'h2B, 8'h3F,
    8'h25, 8'h30, 8'h00, 8'h43, 8'h3F, 8'h22, 8'h30, 8'h00, 8'h43, 8'h3F, 8'h3F, 8'h00, 8'h20, 8'h3F, 8'h00, 8'h20,
    8'h25, 8'h48, 8'h00, 8'h5B, 8'h3F, 8'h22, 8'h48, 8'h00, 8'h5B, 8'h3F, 8'h3F, 8'h00, 8'h20, 8'h3F, 8'h00, 8'h20
  };

  oled_multibar_ctrl #(
    .N_BARS(4), .BAR_W(20), .BAR_GAP(4), .BAR_RGB(24'h3F_00_20), .CLR_WAIT(8)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .force_i(force_i),
    .y_i(y_i), .spi_done_i(spi_done_i), .spi_en_o(spi_en_o), .data_o(data_o),
    .dc_o(dc_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // clock / watchdog
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // spi_master model and byte scoreboard
  initial begin
    int pend;
    logic [7:0] held, exp;
    pend = 0;
    held = 8'h00;
    spi_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      spi_done_i = inject;
      if (!rstn_i) begin
        pend = 0;
      end else if (spi_en_o) begin
        checks++;
        if (pend != 0) begin
          errors++;
          $display("FAIL spi_overlap: spi_en_o with %0d cycles still outstanding, required none", pend);
        end
        checks++;
        if (dc_o !== 1'b0) begin
          errors++;
          $display("FAIL dc: got %b, required 0", dc_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected: got %02h, required no byte", data_o);
        end else begin
          exp = exp_q.pop_front();
          if (data_o !== exp) begin
            errors++;
            $display("FAIL byte: got %02h, required %02h", data_o, exp);
          end
        end
        held = data_o;
        pend = 16;
        bytes_sent++;
      end else if (pend > 0) begin
        checks++;
        if (data_o !== held) begin
          errors++;
          $display("FAIL data_hold: got %02h, required %02h", data_o, held);
        end
        pend--;
        if (pend == 0) spi_done_i = 1'b1;
      end
    end
  end

  task automatic model_reset();
    m_fill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 8'h00;
      m_valid[i]  = 1'b0;
    end
  endtask

  task automatic push_frame(input logic [31:0] y, input logic f);
    logic [7:0] h, x0, x1;
    if (!m_fill) begin
      exp_q.push_back(8'h26);
      exp_q.push_back(8'h01);
      m_fill = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      h = y[8*i +: 8];
      if (h > 8'd64) h = 8'd64;
      if (f || !m_valid[i] || h != m_shadow[i]) begin
        x0 = 8'(i * 24);
        x1 = x0 + 8'd19;
        exp_q.push_back(8'h25); exp_q.push_back(x0); exp_q.push_back(8'h00);
        exp_q.push_back(x1);    exp_q.push_back(8'h3F);
        if (h != 8'd0) begin
          exp_q.push_back(8'h22); exp_q.push_back(x0); exp_q.push_back(8'd64 - h);
          exp_q.push_back(x1);    exp_q.push_back(8'h3F);
          for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h3F); exp_q.push_back(8'h00); exp_q.push_back(8'h20);
          end
        end
        m_shadow[i] = h;
        m_valid[i]  = 1'b1;
      end
    end
  endtask

  // Starts a frame and follows it until busy_o drops; cycle 1 is the first
  // cycle after the edge that samples start_i.
  task automatic run_frame(input logic [31:0] y, input logic f, input int poke,
                           output int cycles, output int dones, output int done_at,
                           output int first_en);
    @(negedge clk_i);
    y_i = y; force_i = f; start_i = 1'b1;
    bytes_sent = 0;
    @(negedge clk_i);
    start_i = 1'b0;
    cycles = 0; dones = 0; done_at = 0; first_en = 0;
    while (busy_o && cycles < 20000) begin
      cycles++;
      if (done_o) begin dones++; done_at = cycles; end
      if (spi_en_o && first_en == 0) first_en = cycles;
      if (cycles == 2) y_i = $urandom();
      start_i = (poke != 0 && cycles == poke);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    checks++;
    if (cycles >= 20000) begin
      errors++;
      $display("FAIL frame_timeout: busy after %0d cycles, required to finish", cycles);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL done_count: got %0d done pulses, required 1", dones);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bytes_missing: %0d expected bytes never sent, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; start_i = 1'b0; force_i = 1'b0; y_i = 32'h0; inject = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if (spi_en_o !== 1'b0 || data_o !== 8'h00 || dc_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: en=%b data=%02h dc=%b busy=%b done=%b state=%0d, required all 0/IDLE",
               spi_en_o, data_o, dc_o, busy_o, done_o, state_o);
    end
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_first_frame();
    int cyc, dn, dat, fe;
    foreach (FRAME1[i]) exp_q.push_back(FRAME1[i]);
    m_fill = 1'b1;
    m_shadow[0] = 8'd10; m_shadow[1] = 8'd0; m_shadow[2] = 8'd64; m_shadow[3] = 8'd64;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b1;
    run_frame({8'd80, 8'd64, 8'd0, 8'd10}, 1'b0, 0, cyc, dn, dat, fe);
    checks++;
    if (fe != 1) begin
      errors++;
      $display("FAIL first_en_latency: first spi_en at cycle %0d, required 1", fe);
    end
    checks++;
    if (bytes_sent != 55) begin
      errors++;
      $display("FAIL first_frame_bytes: got %0d, required 55", bytes_sent);
    end
  endtask

  task automatic test_no_change();
    int cyc, dn, dat, fe;
    push_frame({8'd80, 8'd64, 8'd0, 8'd10}, 1'b0);
    run_frame({8'd80, 8'd64, 8'd0, 8'd10}, 1'b0, 0, cyc, dn, dat, fe);
    checks++;
    if (bytes_sent != 0) begin
      errors++;
      $display("FAIL idle_frame_bytes: got %0d, required 0", bytes_sent);
    end
    checks++;
    if (dat != 6) begin
      errors++;
      $display("FAIL idle_frame_done: done at cycle %0d, required 6", dat);
    end
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL idle_frame_busy: busy for %0d cycles, required 6", cyc);
    end
  endtask

  task automatic test_one_bar();
    int cyc, dn, dat, fe;
    push_frame({8'd80, 8'd64, 8'd5, 8'd10}, 1'b0);
    run_frame({8'd80, 8'd64, 8'd5, 8'd10}, 1'b0, 0, cyc, dn, dat, fe);
    checks++;
    if (bytes_sent != 16) begin
      errors++;
      $display("FAIL one_bar_bytes: got %0d, required 16", bytes_sent);
    end
  endtask

  task automatic test_force();
    int cyc, dn, dat, fe;
    push_frame({8'd80, 8'd64, 8'd5, 8'd10}, 1'b1);
    run_frame({8'd80, 8'd64, 8'd5, 8'd10}, 1'b1, 0, cyc, dn, dat, fe);
    checks++;
    if (bytes_sent != 64) begin
      errors++;
      $display("FAIL force_bytes: got %0d, required 64", bytes_sent);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, dn, dat, fe, extra;
    push_frame({8'd80, 8'd30, 8'd5, 8'd10}, 1'b0);
    run_frame({8'd80, 8'd30, 8'd5, 8'd10}, 1'b0, 10, cyc, dn, dat, fe);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (busy_o || done_o) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_queued: busy/done seen %0d cycles after frame, required 0", extra);
    end
  endtask

  task automatic test_idle_spi_done();
    int bad, cyc, dn, dat, fe;
    @(posedge clk_i); #2 inject = 1'b1;
    @(posedge clk_i); #2 inject = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (busy_o || spi_en_o || state_o != ST_IDLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_spi_done: %0d cycles left IDLE, required 0", bad);
    end
    push_frame({8'd80, 8'd30, 8'd5, 8'd10}, 1'b0);
    run_frame({8'd80, 8'd30, 8'd5, 8'd10}, 1'b0, 0, cyc, dn, dat, fe);
    checks++;
    if (dat != 6) begin
      errors++;
      $display("FAIL idle_spi_done_frame: done at cycle %0d, required 6", dat);
    end
  endtask

  task automatic test_random_frames();
    logic [31:0] y;
    int cyc, dn, dat, fe;
    y = {8'd80, 8'd30, 8'd5, 8'd10};
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 1) == 1) y[8*i +: 8] = 8'($urandom_range(0, 100));
      push_frame(y, 1'b0);
      run_frame(y, 1'b0, 0, cyc, dn, dat, fe);
    end
  endtask

  task automatic test_reset_mid_rect();
    int waited, cyc, dn, dat, fe;
    logic [31:0] y;
    y = {8'd40, 8'd12, 8'd64, 8'd7};
    push_frame(y, 1'b1);
    @(negedge clk_i);
    y_i = y; force_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    waited = 0;
    while (!(spi_en_o && data_o == 8'h22) && waited < 5000) begin
      @(negedge clk_i);
      waited++;
    end
    checks++;
    if (waited >= 5000) begin
      errors++;
      $display("FAIL rect_timeout: no 22 byte within %0d cycles, required one", waited);
    end
    repeat (3) @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if (spi_en_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: en=%b data=%02h busy=%b done=%b, required all 0",
               spi_en_o, data_o, busy_o, done_o);
    end
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    push_frame(y, 1'b0);
    run_frame(y, 1'b0, 0, cyc, dn, dat, fe);
    checks++;
    if (bytes_sent != 2 + 4 * 16) begin
      errors++;
      $display("FAIL post_reset_bytes: got %0d, required 66", bytes_sent);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_no_change();
    test_one_bar();
    test_force();
    test_start_while_busy();
    test_idle_spi_done();
    test_random_frames();
    test_reset_mid_rect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
